// File: rtl/axis_thrust_ctrl.sv
// Per-axis thrust controller: turns pilot accel/brake/zero commands into a saturating
// magnitude+direction velocity and emits one-hot mode/step to the position stage each tick.
module axis_thrust_ctrl #(
  parameter int unsigned VW       = 4,
  parameter int unsigned VMAX     = 7,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  output logic          cmd_ready,
  output logic          update,
  output logic [3:0]    mode,
  output logic [VW-1:0] step,
  output logic [VW-1:0] vel_mag,
  output logic          vel_dir,
  output logic          braking
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StBraking = 2'b01,
    StZeroing = 2'b10
  } state_e;

  localparam logic [2:0] CmdAccPos = 3'b001;
  localparam logic [2:0] CmdAccNeg = 3'b010;
  localparam logic [2:0] CmdBrake  = 3'b011;
  localparam logic [2:0] CmdZero   = 3'b100;

  localparam logic [3:0] ModeHold = 4'b0001;
  localparam logic [3:0] ModeAdd  = 4'b0010;
  localparam logic [3:0] ModeSub  = 4'b0100;
  localparam logic [3:0] ModeLoad = 4'b1000;

  localparam logic [VW-1:0] VMaxV = VW'(VMAX);
  localparam logic [VW-1:0] OneV  = VW'(1);
  localparam logic [CW-1:0] TickV = CW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vel_mag_q, vel_mag_d;
  logic          vel_dir_q, vel_dir_d;
  logic          update_q, update_d;
  logic [3:0]    mode_q, mode_d;
  logic [VW-1:0] step_q, step_d;
  logic          tick;

  assign tick      = (cnt_q == TickV);
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign cmd_ready = (state_q == StIdle);
  assign braking   = (state_q == StBraking);
  assign update    = update_q;
  assign mode      = mode_q;
  assign step      = step_q;
  assign vel_mag   = vel_mag_q;
  assign vel_dir   = vel_dir_q;

  always_comb begin
    state_d   = state_q;
    vel_mag_d = vel_mag_q;
    vel_dir_d = vel_dir_q;
    update_d  = 1'b0;
    mode_d    = ModeHold;
    step_d    = '0;

    // Update always reflects the velocity held during the tick cycle itself.
    if (tick) begin
      update_d = 1'b1;
      if (state_q == StZeroing) begin
        mode_d = ModeLoad;
      end else if (vel_mag_q != '0) begin
        mode_d = vel_dir_q ? ModeSub : ModeAdd;
        step_d = vel_mag_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd)
            CmdAccPos: begin
              if (!vel_dir_q || vel_mag_q == '0) begin
                if (vel_mag_q < VMaxV) vel_mag_d = vel_mag_q + 1'b1;
                vel_dir_d = 1'b0;
              end else begin
                vel_mag_d = vel_mag_q - 1'b1;
                if (vel_mag_q == OneV) vel_dir_d = 1'b0;
              end
            end
            CmdAccNeg: begin
              if (vel_dir_q || vel_mag_q == '0) begin
                if (vel_mag_q < VMaxV) vel_mag_d = vel_mag_q + 1'b1;
                vel_dir_d = 1'b1;
              end else begin
                vel_mag_d = vel_mag_q - 1'b1;
              end
            end
            CmdBrake: begin
              if (vel_mag_q != '0) state_d = StBraking;
            end
            CmdZero: state_d = StZeroing;
            default: ;
          endcase
        end
      end
      StBraking: begin
        if (tick) begin
          if (vel_mag_q <= OneV) begin
            vel_mag_d = '0;
            vel_dir_d = 1'b0;
            state_d   = StIdle;
          end else begin
            vel_mag_d = vel_mag_q - 1'b1;
          end
        end
      end
      StZeroing: begin
        if (tick) begin
          vel_mag_d = '0;
          vel_dir_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        vel_mag_d = '0;
        vel_dir_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      vel_mag_q <= '0;
      vel_dir_q <= 1'b0;
      update_q  <= 1'b0;
      mode_q    <= ModeHold;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vel_mag_q <= vel_mag_d;
      vel_dir_q <= vel_dir_d;
      update_q  <= update_d;
      mode_q    <= mode_d;
      step_q    <= step_d;
    end
  end

endmodule

// File: tb/tb_axis_thrust_ctrl.sv
// Directed bench for axis_thrust_ctrl; expected update pulses are queued as stimulus
// is applied and popped when the DUT raises update.
module tb_axis_thrust_ctrl;

  localparam int VW = 4;
  localparam int TD = 4;

  typedef struct packed {
    logic [3:0]    mode;
    logic [VW-1:0] step;
  } upd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = 3'b000;
  logic          cmd_ready, update, vel_dir, braking;
  logic [3:0]    mode;
  logic [VW-1:0] step, vel_mag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;
  int   n        = 0;
  upd_t sb[$];

  always #5 clk = ~clk;

  axis_thrust_ctrl #(
    .VW      (VW),
    .VMAX    (7),
    .TICK_DIV(TD),
    .CW      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready),
    .update   (update),
    .mode     (mode),
    .step     (step),
    .vel_mag  (vel_mag),
    .vel_dir  (vel_dir),
    .braking  (braking)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    phase = (phase + 1) % TD;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    phase = 0;
    sb.delete();
  endtask

  task automatic send(input logic [2:0] c);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      cyc();
      k++;
    end
    if (k == 20) check("send_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd = c;
    cyc();
    cmd_valid = 1'b0;
    cmd = 3'b000;
  endtask

  task automatic align(input int p);
    while (phase != p) cyc();
  endtask

  task automatic pop_cmp(input string tag);
    upd_t e;
    e = sb.pop_front();
    check({tag, "_mode"}, mode, e.mode);
    check({tag, "_step"}, step, e.step);
  endtask

  // Wait (bounded) for the next update pulse and score it against the queued expectation.
  task automatic expect_upd(input logic [3:0] m, input logic [VW-1:0] s, input string tag,
                            output int waited);
    int k = 0;
    sb.push_back({m, s});
    do begin
      cyc();
      k++;
    end while (!update && k < 3 * TD);
    waited = k;
    check({tag, "_seen"}, update, 1);
    if (update) pop_cmp(tag);
    else void'(sb.pop_front());
  endtask

  initial begin
    // 1: reset state and first update latency
    do_reset();
    check("rst_update", update, 0);
    check("rst_mode", mode, 4'b0001);
    check("rst_step", step, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_vel", vel_mag, 0);
    check("rst_braking", braking, 0);
    expect_upd(4'b0001, 0, "first_upd", n);
    check("first_latency", n, 4);
    cyc();
    check("pulse_one_cycle", update, 0);

    // 2: accelerate positive
    send(3'b001);
    send(3'b001);
    send(3'b001);
    check("acc3_mag", vel_mag, 3);
    check("acc3_dir", vel_dir, 0);
    expect_upd(4'b0010, 3, "acc3_upd_a", n);
    expect_upd(4'b0010, 3, "acc3_upd_b", n);
    check("tick_interval", n, TD);
    send(3'b111);
    check("unknown_mag", vel_mag, 3);
    check("unknown_ready", cmd_ready, 1);

    // 3: negative saturation then reverse
    do_reset();
    for (int i = 0; i < 9; i++) send(3'b010);
    check("sat_mag", vel_mag, 7);
    check("sat_dir", vel_dir, 1);
    expect_upd(4'b0100, 7, "sat_upd", n);
    send(3'b001);
    check("rev_mag", vel_mag, 6);
    check("rev_dir", vel_dir, 1);

    // 4: brake from +3
    do_reset();
    for (int i = 0; i < 3; i++) send(3'b001);
    send(3'b011);
    check("brk_ready", cmd_ready, 0);
    check("brk_braking", braking, 1);
    expect_upd(4'b0010, 3, "brk_upd3", n);
    expect_upd(4'b0010, 2, "brk_upd2", n);
    expect_upd(4'b0010, 1, "brk_upd1", n);
    check("brk_end_mag", vel_mag, 0);
    check("brk_end_dir", vel_dir, 0);
    check("brk_end_ready", cmd_ready, 1);
    check("brk_end_braking", braking, 0);
    expect_upd(4'b0001, 0, "brk_after", n);

    // 5: zero position with a command stalled behind it
    do_reset();
    for (int i = 0; i < 5; i++) send(3'b001);
    align(0);
    send(3'b100);
    check("zero_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd = 3'b001;
    sb.push_back({4'b1000, 4'd0});
    n = 0;
    while (!update && n < 3 * TD) begin
      check("zero_stall_ready", cmd_ready, 0);
      check("zero_stall_mag", vel_mag, 5);
      cyc();
      n++;
    end
    check("zero_seen", update, 1);
    if (update) pop_cmp("zero_upd");
    else void'(sb.pop_front());
    check("zero_mag", vel_mag, 0);
    check("zero_done_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    check("stalled_cmd_mag", vel_mag, 1);

    // 6: accept on a tick cycle, then reset during braking
    do_reset();
    send(3'b001);
    send(3'b001);
    align(TD - 1);
    send(3'b001);
    sb.push_back({4'b0010, 4'd2});
    check("tickacc_seen", update, 1);
    pop_cmp("tickacc_upd");
    check("tickacc_mag", vel_mag, 3);
    expect_upd(4'b0010, 3, "tickacc_next", n);
    send(3'b011);
    cyc();
    cyc();
    check("pre_rst_braking", braking, 1);
    rst = 1'b1;
    cyc();
    check("mid_rst_update", update, 0);
    check("mid_rst_mode", mode, 4'b0001);
    check("mid_rst_step", step, 0);
    check("mid_rst_mag", vel_mag, 0);
    check("mid_rst_dir", vel_dir, 0);
    check("mid_rst_braking", braking, 0);
    check("mid_rst_ready", cmd_ready, 1);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
